// File: rtl/alu_pkg.sv
// Shared types for the ALU command path: opcode enum, command struct and the NOP command.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        OR  = 2'b10,
        XOR = 2'b11
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [3:0] operand;
    } alu_cmd_t;

    localparam alu_cmd_t ALU_NOP = '{op: ADD, operand: 4'h0};

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command store with wrap-around pointers and an occupancy counter.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  alu_cmd_t        wdata_i,
    output alu_cmd_t        rdata_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o
);

    alu_cmd_t        mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CntW'(DEPTH));

endmodule

// File: rtl/alu_cmd_queue.sv
// Command queue feeding an accumulator ALU: registered issue of queued commands, NOP otherwise,
// with hold (stall issue) and flush (discard everything) control.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic            clock,
    input  logic            reset_L,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [3:0]      in_operand,
    input  logic            hold,
    input  logic            flush,
    output logic [1:0]      op,
    output logic [3:0]      operand,
    output logic            issued,
    output logic [CntW-1:0] count
);

    alu_cmd_t        in_cmd;
    alu_cmd_t        head;
    alu_cmd_t        cmd_q, cmd_d;
    logic            issued_q, issued_d;
    logic            full;
    logic            push;
    logic            pop;
    logic [CntW-1:0] fifo_count;

    assign in_cmd = '{op: op_t'(in_op), operand: in_operand};

    // full comes straight from the registered count, so in_ready has no input path.
    assign in_ready = ~full;
    assign push     = in_valid & ~full & ~flush;
    assign pop      = ~hold & ~flush & (fifo_count != '0);

    alu_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clock),
        .rst_ni (reset_L),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(flush),
        .wdata_i(in_cmd),
        .rdata_o(head),
        .count_o(fifo_count),
        .full_o (full)
    );

    always_comb begin
        cmd_d    = ALU_NOP;
        issued_d = 1'b0;
        if (pop) begin
            cmd_d    = head;
            issued_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cmd_q    <= ALU_NOP;
            issued_q <= 1'b0;
        end else begin
            cmd_q    <= cmd_d;
            issued_q <= issued_d;
        end
    end

    assign op      = cmd_q.op;
    assign operand = cmd_q.operand;
    assign issued  = issued_q;
    assign count   = fifo_count;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed self-checking bench for alu_cmd_queue (DEPTH=4) with a bench-side accumulator ALU.
module tb_alu_cmd_queue;

    logic       clock;
    logic       reset_L;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_operand;
    logic       hold;
    logic       flush;
    logic [1:0] op;
    logic [3:0] operand;
    logic       issued;
    logic [2:0] count;
    logic [3:0] acc;

    int checks = 0;
    int errors = 0;

    alu_cmd_queue #(
        .DEPTH(4)
    ) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_operand(in_operand),
        .hold      (hold),
        .flush     (flush),
        .op        (op),
        .operand   (operand),
        .issued    (issued),
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Downstream accumulator: applies op/operand on every rising edge.
    always @(posedge clock or negedge reset_L) begin
        if (!reset_L) acc <= 4'h0;
        else begin
            case (op)
                2'b00: acc <= acc + operand;
                2'b01: acc <= acc - operand;
                2'b10: acc <= acc | operand;
                default: acc <= acc ^ operand;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] cmd);
        in_valid   = v;
        in_op      = cmd[5:4];
        in_operand = cmd[3:0];
    endtask

    task automatic check_out(input string tag, input logic iss, input logic [5:0] cmd);
        check_eq({tag, "_issued"}, 32'(issued), 32'(iss));
        check_eq({tag, "_cmd"}, 32'({op, operand}), 32'(cmd));
    endtask

    logic [5:0] hold_cmds [5];
    logic [5:0] p, q;
    logic       acc_ok;

    initial begin
        hold_cmds[0] = 6'h01; hold_cmds[1] = 6'h12; hold_cmds[2] = 6'h24;
        hold_cmds[3] = 6'h38; hold_cmds[4] = 6'h0f;
        reset_L = 1'b0; hold = 1'b0; flush = 1'b0;
        drive(1'b0, 6'h00);
        #2;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        check_out("rst", 1'b0, 6'h00);
        #6 reset_L = 1'b1;

        // Single command latency: push at edge 1, issued after edge 2, NOP after edge 3.
        drive(1'b1, 6'h13);
        step();
        drive(1'b0, 6'h00);
        check_eq("lat_count1", 32'(count), 32'd1);
        check_out("lat_e1", 1'b0, 6'h00);
        step();
        check_out("lat_e2", 1'b1, 6'h13);
        check_eq("lat_count0", 32'(count), 32'd0);
        step();
        check_out("lat_e3", 1'b0, 6'h00);

        // Hold with five commands offered: four stored, fifth waits.
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, hold_cmds[i]);
            step();
        end
        drive(1'b1, hold_cmds[4]);
        check_eq("hold_count4", 32'(count), 32'd4);
        check_eq("hold_ready0", 32'(in_ready), 32'd0);
        check_eq("hold_issued", 32'(issued), 32'd0);
        step();
        check_eq("hold_full_count", 32'(count), 32'd4);
        check_eq("hold_full_ready", 32'(in_ready), 32'd0);
        hold = 1'b0;
        step();
        check_out("rel0", 1'b1, hold_cmds[0]);
        check_eq("rel0_count", 32'(count), 32'd3);
        step();
        drive(1'b0, 6'h00);
        check_out("rel1", 1'b1, hold_cmds[1]);
        check_eq("rel1_count", 32'(count), 32'd3);
        step();
        check_out("rel2", 1'b1, hold_cmds[2]);
        step();
        check_out("rel3", 1'b1, hold_cmds[3]);
        step();
        check_out("rel4", 1'b1, hold_cmds[4]);
        check_eq("rel4_count", 32'(count), 32'd0);
        step();
        check_out("rel_nop", 1'b0, 6'h00);

        // Streaming from full: one issue per cycle, in order, across several pointer wraps.
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 6'(i));
            step();
        end
        hold = 1'b0;
        p = 6'd4;
        q = 6'd0;
        for (int i = 0; i < 20; i++) begin
            logic acc_now;
            acc_now = in_ready;
            drive(1'b1, p);
            step();
            if (acc_now) p = p + 6'd1;
            check_out("stream", 1'b1, q);
            check_eq("stream_count", 32'(count), 32'd3);
            q = q + 6'd1;
        end
        drive(1'b0, 6'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("drain", 1'b1, q);
            q = q + 6'd1;
        end
        check_eq("drain_count", 32'(count), 32'd0);
        check_eq("drain_total", 32'(q), 32'(p));

        // Flush with a simultaneous push: nothing stored, outputs NOP.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'h20 + 6'(i));
            step();
        end
        check_eq("pre_flush_count", 32'(count), 32'd3);
        drive(1'b1, 6'h3a);
        flush = 1'b1;
        hold  = 1'b0;
        step();
        flush = 1'b0;
        drive(1'b0, 6'h00);
        check_eq("flush_count", 32'(count), 32'd0);
        check_out("flush", 1'b0, 6'h00);
        step();
        check_eq("post_flush_count", 32'(count), 32'd0);
        check_out("post_flush", 1'b0, 6'h00);

        // Asynchronous reset mid-cycle while issuing with two entries left.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'h31 + 6'(i));
            step();
        end
        drive(1'b0, 6'h00);
        hold = 1'b0;
        step();
        check_out("pre_rst", 1'b1, 6'h31);
        check_eq("pre_rst_count", 32'(count), 32'd2);
        #2 reset_L = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 6'h00);
        check_eq("async_rst_count", 32'(count), 32'd0);
        check_eq("async_rst_ready", 32'(in_ready), 32'd1);
        reset_L = 1'b1;
        step();
        check_eq("post_rst_count", 32'(count), 32'd0);
        check_out("post_rst", 1'b0, 6'h00);

        // End-to-end accumulator: add 5, sub 2, xor F, or 1 -> 5, 3, C, D.
        check_eq("acc_init", 32'(acc), 32'd0);
        hold = 1'b1;
        drive(1'b1, 6'h05); step();
        drive(1'b1, 6'h12); step();
        drive(1'b1, 6'h3f); step();
        drive(1'b1, 6'h21); step();
        drive(1'b0, 6'h00);
        hold = 1'b0;
        step();
        check_eq("acc_before", 32'(acc), 32'd0);
        step();
        check_eq("acc_add5", 32'(acc), 32'h5);
        step();
        check_eq("acc_sub2", 32'(acc), 32'h3);
        step();
        check_eq("acc_xorF", 32'(acc), 32'hc);
        step();
        check_eq("acc_or1", 32'(acc), 32'hd);
        step();
        step();
        check_eq("acc_idle", 32'(acc), 32'hd);
        check_out("acc_idle_nop", 1'b0, 6'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
